rr_sched_table: RTL and testbench

Parametrised, table-driven round-robin scheduler that picks which of NUM_Q FIFOs is popped next. A SLOTS-entry schedule table maps each slot to a queue ID, so weights are set by repeating an ID across slots. The table is runtime-writable and the active length is programmable. Two modes are provided: fixed-slot TDM, and work-conserving, which skips empty queues. The block sits between the per-queue FIFO `empty` flags and the pop logic, and offers a registered `pop_id`/`valid` with a `pop_ready` handshake.

---
 rtl/rr_sched_table_if.sv | 28 ++
 rtl/rr_sched_table.sv | 106 ++++++++++
 tb/tb_rr_sched_table.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/rr_sched_table_if.sv
// Bundle of table-programming, queue-status and pop-handshake signals for rr_sched_table.
// The master side is the controller/pop logic, the slave side is the scheduler.
interface rr_sched_table_if #(
  parameter int NUM_Q = 4,
  parameter int IDW   = 2,
  parameter int AW    = 4
);
  logic             tbl_we;
  logic [AW-1:0]    tbl_addr;
  logic [IDW-1:0]   tbl_data;
  logic [AW-1:0]    num_slots;
  logic             mode;
  logic [NUM_Q-1:0] empty;
  logic             pop_ready;
  logic [IDW-1:0]   pop_id;
  logic             valid;
  logic [AW-1:0]    slot_ptr;

  modport master (
    output tbl_we, tbl_addr, tbl_data, num_slots, mode, empty, pop_ready,
    input  pop_id, valid, slot_ptr
  );

  modport slave (
    input  tbl_we, tbl_addr, tbl_data, num_slots, mode, empty, pop_ready,
    output pop_id, valid, slot_ptr
  );
endinterface

// File: rtl/rr_sched_table.sv
// Table-driven round-robin pop scheduler: fixed-slot TDM (mode 0) or work-conserving
// scan that skips empty queues (mode 1), with a registered pop_id/valid offer.
module rr_sched_table #(
  parameter int NUM_Q = 4,
  parameter int SLOTS = 10,
  parameter int IDW   = $clog2(NUM_Q),
  parameter int AW    = $clog2(SLOTS + 1)
) (
  input logic              clk,
  input logic              reset,
  rr_sched_table_if.slave  bus
);

  logic [IDW-1:0] tbl [SLOTS];
  logic [IDW-1:0] pop_id_q, pop_id_d;
  logic           valid_q, valid_d;
  logic [AW-1:0]  ptr_q, ptr_d;

  logic [AW-1:0]  eff_len;
  logic [AW-1:0]  sel_ptr;
  logic [AW-1:0]  fix_next;
  logic [IDW-1:0] fix_id;
  logic           fix_ok;
  logic           scan_found;
  logic [IDW-1:0] scan_id;
  logic [AW-1:0]  scan_next;
  logic [AW:0]    sum;
  logic           decide;

  // IDs at or beyond NUM_Q never match a queue, so such slots read as empty.
  function automatic logic slot_ok(input logic [IDW-1:0] q, input logic [NUM_Q-1:0] emp);
    logic ok;
    ok = 1'b0;
    for (int i = 0; i < NUM_Q; i++) begin
      if (q == IDW'(i)) ok = !emp[i];
    end
    return ok;
  endfunction

  always_comb begin
    eff_len = bus.num_slots;
    if (bus.num_slots == '0) eff_len = AW'(1);
    else if (bus.num_slots > AW'(SLOTS)) eff_len = AW'(SLOTS);
    sel_ptr  = (ptr_q >= eff_len) ? '0 : ptr_q;
    fix_next = ((sel_ptr + AW'(1)) >= eff_len) ? '0 : sel_ptr + AW'(1);
    fix_id   = tbl[sel_ptr];
    fix_ok   = slot_ok(fix_id, bus.empty);
  end

  // Offsets past the effective length are masked; the modulo sum always stays inside the table.
  always_comb begin
    scan_found = 1'b0;
    scan_id    = '0;
    scan_next  = ptr_q;
    sum        = '0;
    for (int k = 0; k < SLOTS; k++) begin
      sum = {1'b0, sel_ptr} + (AW+1)'(k);
      if (sum >= {1'b0, eff_len}) sum = sum - {1'b0, eff_len};
      if (!scan_found && ((AW+1)'(k) < {1'b0, eff_len}) &&
          slot_ok(tbl[sum[AW-1:0]], bus.empty)) begin
        scan_found = 1'b1;
        scan_id    = tbl[sum[AW-1:0]];
        scan_next  = ((sum[AW-1:0] + AW'(1)) >= eff_len) ? '0 : sum[AW-1:0] + AW'(1);
      end
    end
  end

  always_comb begin
    pop_id_d = pop_id_q;
    valid_d  = valid_q;
    ptr_d    = ptr_q;
    decide   = !valid_q || bus.pop_ready;
    if (decide) begin
      if (!bus.mode) begin
        valid_d = fix_ok;
        if (fix_ok) pop_id_d = fix_id;
        ptr_d = fix_next;
      end else begin
        valid_d = scan_found;
        if (scan_found) begin
          pop_id_d = scan_id;
          ptr_d    = scan_next;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pop_id_q <= '0;
      valid_q  <= 1'b0;
      ptr_q    <= '0;
      for (int i = 0; i < SLOTS; i++) tbl[i] <= IDW'(i % NUM_Q);
    end else begin
      pop_id_q <= pop_id_d;
      valid_q  <= valid_d;
      ptr_q    <= ptr_d;
      if (bus.tbl_we && (bus.tbl_addr < AW'(SLOTS))) tbl[bus.tbl_addr] <= bus.tbl_data;
    end
  end

  assign bus.pop_id   = pop_id_q;
  assign bus.valid    = valid_q;
  assign bus.slot_ptr = ptr_q;

endmodule

// File: tb/tb_rr_sched_table.sv
// Directed bench for rr_sched_table: inputs change and outputs are sampled on the falling edge.
module tb_rr_sched_table;
  localparam int NUM_Q = 4;
  localparam int SLOTS = 10;
  localparam int IDW   = 2;
  localparam int AW    = 4;

  logic clk = 1'b0;
  logic reset;
  int   checks = 0;
  int   passes = 0;

  rr_sched_table_if #(.NUM_Q(NUM_Q), .IDW(IDW), .AW(AW)) bus ();

  rr_sched_table #(.NUM_Q(NUM_Q), .SLOTS(SLOTS)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    bus.tbl_we = 1'b0;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    bus.tbl_we = 1'b0; bus.tbl_addr = '0; bus.tbl_data = '0;
    bus.num_slots = 4'd10; bus.mode = 1'b0; bus.empty = 4'b0000; bus.pop_ready = 1'b1;
    tick();
    tick();
    checks++;
    if (bus.valid !== 1'b0) $display("[TB] FAIL reset_valid got %0b want 0", bus.valid); else passes++;
    checks++;
    if (bus.pop_id !== 2'd0) $display("[TB] FAIL reset_pop_id got %0d want 0", bus.pop_id); else passes++;
    checks++;
    if (bus.slot_ptr !== 4'd0) $display("[TB] FAIL reset_slot_ptr got %0d want 0", bus.slot_ptr); else passes++;
    reset = 1'b0;
  endtask

  task automatic test_fixed();
    for (int i = 0; i < 20; i++) begin
      tick();
      checks++;
      if (bus.valid !== 1'b1 || bus.pop_id !== IDW'((i % 10) % 4))
        $display("[TB] FAIL fixed[%0d] got valid=%0b id=%0d want valid=1 id=%0d", i, bus.valid, bus.pop_id, (i % 10) % 4);
      else passes++;
      checks++;
      if (bus.slot_ptr !== AW'((i + 1) % 10))
        $display("[TB] FAIL fixed_ptr[%0d] got %0d want %0d", i, bus.slot_ptr, (i + 1) % 10);
      else passes++;
    end
  endtask

  task automatic test_fixed_empty();
    int q;
    do_reset();
    bus.mode = 1'b0; bus.num_slots = 4'd10; bus.empty = 4'b0100; bus.pop_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      q = i % 4;
      checks++;
      if (bus.valid !== (q != 2))
        $display("[TB] FAIL fixed_empty_valid[%0d] got %0b want %0b", i, bus.valid, (q != 2));
      else passes++;
      checks++;
      if (bus.pop_id !== IDW'((q == 2) ? 1 : q))
        $display("[TB] FAIL fixed_empty_id[%0d] got %0d want %0d", i, bus.pop_id, (q == 2) ? 1 : q);
      else passes++;
    end
  endtask

  task automatic test_work_conserving();
    int exp_id [10]  = '{0, 1, 3, 0, 1, 3, 0, 1, 0, 1};
    int exp_ptr [10] = '{1, 2, 4, 5, 6, 8, 9, 0, 1, 2};
    do_reset();
    bus.mode = 1'b1; bus.num_slots = 4'd10; bus.empty = 4'b0100; bus.pop_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++;
      if (bus.valid !== 1'b1 || bus.pop_id !== IDW'(exp_id[i]))
        $display("[TB] FAIL wc[%0d] got valid=%0b id=%0d want valid=1 id=%0d", i, bus.valid, bus.pop_id, exp_id[i]);
      else passes++;
      checks++;
      if (bus.slot_ptr !== AW'(exp_ptr[i]))
        $display("[TB] FAIL wc_ptr[%0d] got %0d want %0d", i, bus.slot_ptr, exp_ptr[i]);
      else passes++;
    end
  endtask

  task automatic test_weighted();
    int exp_id [9] = '{0, 0, 0, 1, 0, 0, 0, 1, 0};
    int q0_grants = 0;
    do_reset();
    bus.mode = 1'b1; bus.num_slots = 4'd10; bus.empty = 4'b1111; bus.pop_ready = 1'b1;
    for (int a = 0; a < 4; a++) begin
      bus.tbl_we = 1'b1; bus.tbl_addr = AW'(a); bus.tbl_data = (a == 3) ? 2'd1 : 2'd0;
      tick();
    end
    bus.tbl_we = 1'b0;
    checks++;
    if (bus.valid !== 1'b0 || bus.slot_ptr !== 4'd0)
      $display("[TB] FAIL weighted_idle got valid=%0b ptr=%0d want valid=0 ptr=0", bus.valid, bus.slot_ptr);
    else passes++;
    bus.num_slots = 4'd4; bus.empty = 4'b0000;
    for (int i = 0; i < 9; i++) begin
      tick();
      if (i < 8 && bus.valid === 1'b1 && bus.pop_id === 2'd0) q0_grants++;
      checks++;
      if (bus.valid !== 1'b1 || bus.pop_id !== IDW'(exp_id[i]))
        $display("[TB] FAIL weighted[%0d] got valid=%0b id=%0d want valid=1 id=%0d", i, bus.valid, bus.pop_id, exp_id[i]);
      else passes++;
    end
    checks++;
    if (q0_grants !== 6) $display("[TB] FAIL weighted_share got %0d want 6", q0_grants); else passes++;
    bus.empty = 4'b1111;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (bus.valid !== 1'b0 || bus.slot_ptr !== 4'd1)
        $display("[TB] FAIL all_empty[%0d] got valid=%0b ptr=%0d want valid=0 ptr=1", i, bus.valid, bus.slot_ptr);
      else passes++;
    end
  endtask

  task automatic test_handshake();
    do_reset();
    bus.mode = 1'b0; bus.num_slots = 4'd10; bus.empty = 4'b0000; bus.pop_ready = 1'b1;
    tick(); tick(); tick();
    checks++;
    if (bus.valid !== 1'b1 || bus.pop_id !== 2'd2 || bus.slot_ptr !== 4'd3)
      $display("[TB] FAIL hs_setup got valid=%0b id=%0d ptr=%0d want 1/2/3", bus.valid, bus.pop_id, bus.slot_ptr);
    else passes++;
    bus.pop_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      bus.empty = (i % 2 == 0) ? 4'b0100 : 4'b0000;
      tick();
      checks++;
      if (bus.valid !== 1'b1 || bus.pop_id !== 2'd2 || bus.slot_ptr !== 4'd3)
        $display("[TB] FAIL hs_hold[%0d] got valid=%0b id=%0d ptr=%0d want 1/2/3", i, bus.valid, bus.pop_id, bus.slot_ptr);
      else passes++;
    end
    // Release together with a write to slot 3: the decision must still see the old entry.
    bus.pop_ready = 1'b1; bus.empty = 4'b0000;
    bus.tbl_we = 1'b1; bus.tbl_addr = 4'd3; bus.tbl_data = 2'd0;
    tick();
    bus.tbl_we = 1'b0;
    checks++;
    if (bus.valid !== 1'b1 || bus.pop_id !== 2'd3 || bus.slot_ptr !== 4'd4)
      $display("[TB] FAIL hs_release got valid=%0b id=%0d ptr=%0d want 1/3/4", bus.valid, bus.pop_id, bus.slot_ptr);
    else passes++;
  endtask

  task automatic test_shrink();
    int exp_id [3]  = '{1, 2, 0};
    int exp_ptr [3] = '{2, 0, 1};
    do_reset();
    bus.mode = 1'b0; bus.num_slots = 4'd10; bus.empty = 4'b0000; bus.pop_ready = 1'b1;
    for (int i = 0; i < 7; i++) tick();
    checks++;
    if (bus.slot_ptr !== 4'd7 || bus.pop_id !== 2'd2)
      $display("[TB] FAIL shrink_setup got ptr=%0d id=%0d want ptr=7 id=2", bus.slot_ptr, bus.pop_id);
    else passes++;
    bus.num_slots = 4'd3;
    tick();
    checks++;
    if (bus.pop_id !== 2'd0 || bus.slot_ptr !== 4'd1)
      $display("[TB] FAIL shrink_wrap got id=%0d ptr=%0d want id=0 ptr=1", bus.pop_id, bus.slot_ptr);
    else passes++;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (bus.pop_id !== IDW'(exp_id[i]) || bus.slot_ptr !== AW'(exp_ptr[i]))
        $display("[TB] FAIL len3[%0d] got id=%0d ptr=%0d want id=%0d ptr=%0d", i, bus.pop_id, bus.slot_ptr, exp_id[i], exp_ptr[i]);
      else passes++;
    end
    bus.num_slots = 4'd0;
    for (int i = 0; i < 3; i++) begin
      bus.tbl_we = (i == 0); bus.tbl_addr = 4'd12; bus.tbl_data = 2'd3;
      tick();
      checks++;
      if (bus.valid !== 1'b1 || bus.pop_id !== 2'd0 || bus.slot_ptr !== 4'd0)
        $display("[TB] FAIL len0[%0d] got valid=%0b id=%0d ptr=%0d want 1/0/0", i, bus.valid, bus.pop_id, bus.slot_ptr);
      else passes++;
    end
    bus.tbl_we = 1'b0;
    bus.num_slots = 4'd15;
    for (int i = 0; i < 11; i++) begin
      tick();
      checks++;
      if (bus.pop_id !== IDW'((i % 10) % 4) || bus.slot_ptr !== AW'((i + 1) % 10))
        $display("[TB] FAIL len_clamp[%0d] got id=%0d ptr=%0d want id=%0d ptr=%0d", i, bus.pop_id, bus.slot_ptr, (i % 10) % 4, (i + 1) % 10);
      else passes++;
    end
  endtask

  task automatic test_reset_midstream();
    do_reset();
    bus.mode = 1'b0; bus.num_slots = 4'd10; bus.empty = 4'b0000; bus.pop_ready = 1'b1;
    bus.tbl_we = 1'b1; bus.tbl_addr = 4'd1; bus.tbl_data = 2'd3;
    tick();
    bus.tbl_we = 1'b0;
    checks++;
    if (bus.pop_id !== 2'd0 || bus.slot_ptr !== 4'd1)
      $display("[TB] FAIL mid_first got id=%0d ptr=%0d want id=0 ptr=1", bus.pop_id, bus.slot_ptr);
    else passes++;
    tick();
    checks++;
    if (bus.valid !== 1'b1 || bus.pop_id !== 2'd3)
      $display("[TB] FAIL mid_written got valid=%0b id=%0d want valid=1 id=3", bus.valid, bus.pop_id);
    else passes++;
    reset = 1'b1;
    bus.tbl_we = 1'b1; bus.tbl_addr = 4'd0; bus.tbl_data = 2'd2;
    tick();
    checks++;
    if (bus.valid !== 1'b0 || bus.pop_id !== 2'd0 || bus.slot_ptr !== 4'd0)
      $display("[TB] FAIL mid_reset got valid=%0b id=%0d ptr=%0d want 0/0/0", bus.valid, bus.pop_id, bus.slot_ptr);
    else passes++;
    reset = 1'b0;
    bus.tbl_we = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      checks++;
      if (bus.valid !== 1'b1 || bus.pop_id !== IDW'(i))
        $display("[TB] FAIL mid_restored[%0d] got valid=%0b id=%0d want valid=1 id=%0d", i, bus.valid, bus.pop_id, i);
      else passes++;
    end
  endtask

  initial begin
    test_reset();
    test_fixed();
    test_fixed_empty();
    test_work_conserving();
    test_weighted();
    test_handshake();
    test_shrink();
    test_reset_midstream();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
